// File: rtl/cpu_param.sv
// Parametrised two-word-instruction accumulator CPU with host program-load port.
// Optional single-step input is enabled by defining CPU_STEP_EN.
module cpu_param #(
    parameter int DATA_W  = 4,
    parameter int IMEM_AW = 4,
    parameter int DMEM_AW = 2
) (
    input  logic               clk,
    input  logic               reset_n,
`ifdef CPU_STEP_EN
    input  logic               step,
`endif
    input  logic               start,
    input  logic               prog_we,
    input  logic               prog_sel,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [DATA_W-1:0]  prog_data,
    output logic [DATA_W-1:0]  acc,
    output logic [IMEM_AW-1:0] pc,
    output logic               busy,
    output logic               halted,
    output logic               zero,
    output logic               carry,
    output logic               illegal
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDM = 4'h2, OP_STM = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB;
    localparam logic [3:0] OP_ILC = 4'hC, OP_ILD = 4'hD, OP_ILE = 4'hE, OP_HLT = 4'hF;
    localparam logic [IMEM_AW-1:0] PC_ONE = IMEM_AW'(1);

    logic [DATA_W-1:0]  imem_r [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem_r [2**DMEM_AW];

    state_t             state_r;
    logic [DATA_W-1:0]  acc_r, ir_r, arg_r;
    logic [IMEM_AW-1:0] pc_r;
    logic               zero_r, carry_r, illegal_r, busy_r, halted_r;

    logic               idle_s, step_ok_s, imem_we_s, dmem_we_s;
    logic [3:0]         opcode_s;
    logic [DMEM_AW-1:0] dmem_addr_s, dmem_wa_s;
    logic [DATA_W-1:0]  dmem_rd_s, dmem_wd_s;
    logic [IMEM_AW-1:0] target_s;
    logic [DATA_W:0]    sum_s, diff_s;
    logic [DATA_W-1:0]  alu_acc_s;
    logic               alu_zero_s, alu_carry_s, zero_we_s, jump_s, halt_s, ill_s;

    assign acc     = acc_r;
    assign pc      = pc_r;
    assign busy    = busy_r;
    assign halted  = halted_r;
    assign zero    = zero_r;
    assign carry   = carry_r;
    assign illegal = illegal_r;

`ifdef CPU_STEP_EN
    assign step_ok_s = step;
`else
    assign step_ok_s = 1'b1;
`endif

    // Jump target is the low operand bits, zero-extended when the operand is narrower than the PC.
    if (DATA_W >= IMEM_AW) begin : g_tgt_slice
        assign target_s = arg_r[IMEM_AW-1:0];
    end else begin : g_tgt_ext
        assign target_s = {{(IMEM_AW-DATA_W){1'b0}}, arg_r};
    end

    assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_HALTED);
    assign opcode_s    = ir_r[3:0];
    assign dmem_addr_s = arg_r[DMEM_AW-1:0];
    assign dmem_rd_s   = dmem_r[dmem_addr_s];
    assign sum_s       = {1'b0, acc_r} + {1'b0, dmem_rd_s};
    assign diff_s      = {1'b0, acc_r} - {1'b0, dmem_rd_s};
    assign imem_we_s   = idle_s && prog_we && !prog_sel;

    // Data-memory write port: host loads while idle, STM during execute.
    always_comb begin
        dmem_we_s = 1'b0;
        dmem_wa_s = prog_addr[DMEM_AW-1:0];
        dmem_wd_s = prog_data;
        if (idle_s && prog_we && prog_sel) begin
            dmem_we_s = 1'b1;
        end else if ((state_r == ST_EXEC) && (opcode_s == OP_STM)) begin
            dmem_we_s = 1'b1;
            dmem_wa_s = dmem_addr_s;
            dmem_wd_s = acc_r;
        end else begin
            dmem_we_s = 1'b0;
        end
    end

    // Instruction decode and ALU result for the execute cycle.
    always_comb begin
        alu_acc_s   = acc_r;
        alu_carry_s = carry_r;
        zero_we_s   = 1'b0;
        jump_s      = 1'b0;
        halt_s      = 1'b0;
        ill_s       = 1'b0;
        case (opcode_s)
            OP_NOP, OP_STM: ;
            OP_LDI: begin alu_acc_s = arg_r;     zero_we_s = 1'b1; end
            OP_LDM: begin alu_acc_s = dmem_rd_s; zero_we_s = 1'b1; end
            OP_ADD: begin {alu_carry_s, alu_acc_s} = sum_s; zero_we_s = 1'b1; end
            OP_SUB: begin {alu_carry_s, alu_acc_s} = diff_s; zero_we_s = 1'b1; end
            OP_AND: begin alu_acc_s = acc_r & dmem_rd_s; zero_we_s = 1'b1; end
            OP_OR:  begin alu_acc_s = acc_r | dmem_rd_s; zero_we_s = 1'b1; end
            OP_XOR: begin alu_acc_s = acc_r ^ dmem_rd_s; zero_we_s = 1'b1; end
            OP_JMP: jump_s = 1'b1;
            OP_JZ:  jump_s = zero_r;
            OP_JC:  jump_s = carry_r;
            OP_ILC, OP_ILD, OP_ILE: ill_s = 1'b1;
            OP_HLT: halt_s = 1'b1;
            default: ;
        endcase
        if (zero_we_s) begin
            alu_zero_s = (alu_acc_s == {DATA_W{1'b0}});
        end else begin
            alu_zero_s = zero_r;
        end
    end

    // Memory arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (imem_we_s) begin
            imem_r[prog_addr] <= prog_data;
        end
        if (dmem_we_s) begin
            dmem_r[dmem_wa_s] <= dmem_wd_s;
        end
    end

    // Control FSM with architectural state and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            acc_r     <= '0;
            pc_r      <= '0;
            ir_r      <= '0;
            arg_r     <= '0;
            zero_r    <= 1'b0;
            carry_r   <= 1'b0;
            illegal_r <= 1'b0;
            busy_r    <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        pc_r      <= '0;
                        zero_r    <= 1'b0;
                        carry_r   <= 1'b0;
                        illegal_r <= 1'b0;
                        busy_r    <= 1'b1;
                        halted_r  <= 1'b0;
                        state_r   <= ST_FETCH_OP;
                    end
                end
                ST_FETCH_OP: begin
                    if (step_ok_s) begin
                        ir_r    <= imem_r[pc_r];
                        pc_r    <= pc_r + PC_ONE;
                        state_r <= ST_FETCH_ARG;
                    end
                end
                ST_FETCH_ARG: begin
                    arg_r   <= imem_r[pc_r];
                    pc_r    <= pc_r + PC_ONE;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    acc_r   <= alu_acc_s;
                    zero_r  <= alu_zero_s;
                    carry_r <= alu_carry_s;
                    if (ill_s) begin
                        illegal_r <= 1'b1;
                    end
                    if (jump_s) begin
                        pc_r <= target_s;
                    end
                    if (halt_s) begin
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                        state_r  <= ST_HALTED;
                    end else begin
                        state_r  <= ST_FETCH_OP;
                    end
                end
                default: begin
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_param.sv
// Randomised and directed bench for cpu_param against an instruction-level interpreter.
module tb_cpu_param;

    localparam int DW = 4, IAW = 4, DAW = 2;
    localparam int DMOD = 1 << DW, ISZ = 1 << IAW, DSZ = 1 << DAW;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, step = 1'b1;
    logic prog_we = 1'b0, prog_sel = 1'b0;
    logic [IAW-1:0] prog_addr = '0;
    logic [DW-1:0]  prog_data = '0;
    logic [DW-1:0]  acc;
    logic [IAW-1:0] pc;
    logic busy, halted, zero, carry, illegal;

    int n_tests = 0, n_fail = 0;
    int m_imem [ISZ];
    int m_dmem [DSZ];
    int m_acc = 0, m_z = 0, m_c = 0, m_ill = 0, m_pc = 0;
    int prog_q [$];

    cpu_param dut (
        .clk(clk), .reset_n(reset_n),
`ifdef CPU_STEP_EN
        .step(step),
`endif
        .start(start), .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .acc(acc), .pc(pc), .busy(busy), .halted(halted),
        .zero(zero), .carry(carry), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Interpret the program from word 0 until HLT, counting three cycles per instruction.
    task automatic model_run(output int cyc);
        int p, op, arg, a, r;
        bit done;
        p = 0; cyc = 0; done = 0;
        m_z = 0; m_c = 0; m_ill = 0;
        while (!done && cyc < 3000) begin
            op  = m_imem[p] % 16;
            arg = m_imem[(p + 1) % ISZ];
            p   = (p + 2) % ISZ;
            a   = arg % DSZ;
            cyc += 3;
            case (op)
                1: begin m_acc = arg;       m_z = (m_acc == 0); end
                2: begin m_acc = m_dmem[a]; m_z = (m_acc == 0); end
                3: m_dmem[a] = m_acc;
                4: begin r = m_acc + m_dmem[a]; m_c = (r >= DMOD); m_acc = r % DMOD; m_z = (m_acc == 0); end
                5: begin m_c = (m_acc < m_dmem[a]); m_acc = (m_acc - m_dmem[a] + DMOD) % DMOD; m_z = (m_acc == 0); end
                6: begin m_acc = m_acc & m_dmem[a]; m_z = (m_acc == 0); end
                7: begin m_acc = m_acc | m_dmem[a]; m_z = (m_acc == 0); end
                8: begin m_acc = m_acc ^ m_dmem[a]; m_z = (m_acc == 0); end
                9: p = arg % ISZ;
                10: if (m_z != 0) p = arg % ISZ;
                11: if (m_c != 0) p = arg % ISZ;
                12, 13, 14: m_ill = 1;
                15: done = 1;
                default: ;
            endcase
        end
        m_pc = p;
    endtask

    task automatic pwrite(input bit sel, input int addr, input int data, input bit upd);
        @(negedge clk);
        prog_we = 1'b1; prog_sel = sel;
        prog_addr = IAW'(addr); prog_data = DW'(data);
        @(negedge clk);
        prog_we = 1'b0;
        if (upd) begin
            if (sel) m_dmem[addr % DSZ] = data % DMOD;
            else     m_imem[addr % ISZ] = data % DMOD;
        end
    endtask

    task automatic load_prog();
        foreach (prog_q[i]) pwrite(1'b0, i, prog_q[i], 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(output int cyc, output int mcyc);
        pulse_start();
        wait_halt(cyc);
        model_run(mcyc);
    endtask

    int cyc, mcyc;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_acc", acc, 0);   check("rst_pc", pc, 0);
        check("rst_busy", busy, 0); check("rst_halted", halted, 0);
        check("rst_flags", {zero, carry, illegal}, 0);
        reset_n = 1'b1;

        // LDI 3; ADD 0; HLT with dmem[0]=4
        pwrite(1'b1, 0, 4, 1'b1);
        prog_q = '{1, 3, 4, 0, 15, 0};
        load_prog();
        run(cyc, mcyc);
        check("add_cyc", cyc, 9);  check("add_acc", acc, 7);
        check("add_c", carry, 0);  check("add_z", zero, 0);
        check("add_pc", pc, 6);    check("add_halted", halted, 1);

        // Asynchronous reset in the middle of EXEC
        pulse_start();
        repeat (2) @(negedge clk);
        check("midexec_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_acc", acc, 0);   check("arst_pc", pc, 0);
        check("arst_busy", busy, 0); check("arst_halted", halted, 0);
        check("arst_flags", {zero, carry, illegal}, 0);
        m_acc = 0;
        @(negedge clk) reset_n = 1'b1;

`ifdef CPU_STEP_EN
        step = 1'b0;
        prog_q = '{1, 5, 15, 0};
        load_prog();
        pulse_start();
        repeat (5) @(negedge clk);
        check("step_hold_pc", pc, 0); check("step_hold_acc", acc, 0);
        check("step_hold_busy", busy, 1);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        repeat (3) @(negedge clk);
        check("step1_acc", acc, 5); check("step1_halted", halted, 0);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        repeat (3) @(negedge clk);
        check("step2_halted", halted, 1);
        m_acc = 5;
        step = 1'b1;
`endif

        // SUB with borrow, then SUB to zero
        pwrite(1'b1, 1, 4, 1'b1);
        prog_q = '{1, 2, 5, 1, 15, 0};
        load_prog();
        run(cyc, mcyc);
        check("sub_acc", acc, 14); check("sub_c", carry, 1); check("sub_z", zero, 0);
        pwrite(1'b0, 1, 4, 1'b1);
        run(cyc, mcyc);
        check("sub0_acc", acc, 0); check("sub0_z", zero, 1); check("sub0_c", carry, 0);

        // Countdown loop: LDI 3; SUB 1; JZ 8; JMP 2; HLT at 8
        pwrite(1'b1, 1, 1, 1'b1);
        prog_q = '{1, 3, 5, 1, 10, 8, 9, 2, 15, 0};
        load_prog();
        run(cyc, mcyc);
        check("loop_cyc", cyc, 30); check("loop_acc", acc, 0);
        check("loop_z", zero, 1);   check("loop_halted", halted, 1);

        // Host write while busy must be dropped
        prog_q = '{1, 9, 15, 0};
        load_prog();
        pulse_start();
        pwrite(1'b0, 1, 6, 1'b0);
        wait_halt(cyc);
        check("busywr_acc1", acc, 9);
        run(cyc, mcyc);
        check("busywr_acc2", acc, 9);

        // Undefined opcode sets illegal; restart with simultaneous write clears it
        prog_q = '{12, 0, 15, 0};
        load_prog();
        run(cyc, mcyc);
        check("ill_flag", illegal, 1); check("ill_acc", acc, 9); check("ill_halted", halted, 1);
        @(negedge clk);
        start = 1'b1; prog_we = 1'b1; prog_sel = 1'b0; prog_addr = '0; prog_data = '0;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        m_imem[0] = 0;
        wait_halt(cyc);
        check("restart_cyc", cyc, 6); check("restart_ill", illegal, 0);

        for (int i = 0; i < DSZ; i++) pwrite(1'b1, i, $urandom_range(0, DMOD - 1), 1'b1);

        // Random forward-jumping programs ending in HLT at word 14
        for (int t = 0; t < 25; t++) begin
            prog_q = {};
            for (int i = 0; i < 7; i++) begin
                int op;
                op = $urandom_range(0, 14);
                prog_q.push_back(op);
                if (op >= 9 && op <= 11) prog_q.push_back(2 * $urandom_range(i + 1, 7));
                else                     prog_q.push_back($urandom_range(0, DMOD - 1));
            end
            prog_q.push_back(15);
            prog_q.push_back($urandom_range(0, DMOD - 1));
            load_prog();
            if ($urandom_range(0, 1) == 1) pwrite(1'b1, $urandom_range(0, ISZ - 1), $urandom_range(0, DMOD - 1), 1'b1);
            run(cyc, mcyc);
            check("rnd_cyc", cyc, mcyc);  check("rnd_acc", acc, m_acc);
            check("rnd_z", zero, m_z);    check("rnd_c", carry, m_c);
            check("rnd_ill", illegal, m_ill); check("rnd_pc", pc, m_pc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
